// File: rtl/hash_sample_unpack.sv
// hash_sample_unpack
//   Sits between the SHAKE squeeze output and the hash address generator /
//   sample memory. Each accepted 64-bit hash word is split into four 16-bit
//   samples, lane 0 first, one per cycle. Samples are counted per job and a
//   one-cycle done pulse marks completion.
//
// Ports
//   clk, rstn          clock, asynchronous active-low reset
//   start, abort       job start (IDLE only), synchronous job kill
//   mode[2:0]          job type (000 S/S', 001 E', 010 E, 100 B, 101 B')
//   level[1:0]         parameter set (01 n=1344, 10 n=976, 11 n=640, 00 n=0)
//   busy, done         job in progress (CLR/RUN), completion pulse
//   hash_valid/ready   hash word handshake, hash_data[63:0] word
//   smp_we, smp_data   sample write strobe and value
//   agu_addr_clr       address generator clear (CLR state)
//   agu_add_en         address generator step, same as smp_we
//   agu_mode/level     mode and level latched at job start
module hash_sample_unpack #(
  parameter int W_HASH = 64,
  parameter int W_SMP  = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              abort,
  input  logic [2:0]        mode,
  input  logic [1:0]        level,
  output logic              busy,
  output logic              done,
  input  logic              hash_valid,
  input  logic [W_HASH-1:0] hash_data,
  output logic              hash_ready,
  output logic              smp_we,
  output logic [W_SMP-1:0]  smp_data,
  output logic              agu_addr_clr,
  output logic              agu_add_en,
  output logic [2:0]        agu_mode,
  output logic [1:0]        agu_level
);

  typedef enum logic [1:0] {IDLE, CLR, RUN, DONE} state_t;

  state_t            state, state_next;
  logic [W_HASH-1:0] buf_q;
  logic              buf_valid;
  logic [1:0]        lane;       // lane of the sample currently on smp_data
  logic [13:0]       remaining;  // samples still to emit, including the current one
  logic              hs;
  logic              last_smp;

  function automatic logic [13:0] total(input logic [2:0] m, input logic [1:0] l);
    logic [13:0] n;
    case (l)
      2'b01:   n = 14'd1344;
      2'b10:   n = 14'd976;
      2'b11:   n = 14'd640;
      default: n = '0;
    endcase
    case (m)
      3'b000, 3'b010, 3'b101: total = {n[10:0], 3'b000};
      3'b001:                 total = (n != '0) ? 14'd64 : '0;
      3'b100:                 total = n;
      default:                total = '0;
    endcase
  endfunction

  // A new word may be taken while lane 3 is on the output, so words chain
  // back-to-back without a bubble; never after the final sample.
  assign hash_ready = (state == RUN) &&
                      (!buf_valid || (lane == 2'd3 && remaining > 14'd1));
  assign hs         = hash_valid && hash_ready;
  assign last_smp   = (state == RUN) && buf_valid && (remaining == 14'd1);

  // The output sample is the registered buffer lane, so smp_we follows the
  // buffer valid flag directly.
  assign smp_we       = buf_valid;
  assign agu_add_en   = buf_valid;
  assign smp_data     = buf_q[W_SMP*lane +: W_SMP];
  assign busy         = (state == CLR) || (state == RUN);
  assign done         = (state == DONE);
  assign agu_addr_clr = (state == CLR);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (abort) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: if (start) state_next = CLR;
        CLR:  state_next = (remaining == '0) ? DONE : RUN;
        RUN:  if (last_smp) state_next = DONE;
        DONE: state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      buf_q     <= '0;
      buf_valid <= 1'b0;
      lane      <= '0;
      remaining <= '0;
      agu_mode  <= '0;
      agu_level <= '0;
    end else if (abort) begin
      buf_valid <= 1'b0;
      lane      <= '0;
      remaining <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            agu_mode  <= mode;
            agu_level <= level;
            remaining <= total(mode, level);
          end
        end
        RUN: begin
          if (hs) buf_q <= hash_data;
          if (buf_valid) begin
            remaining <= remaining - 14'd1;
            lane      <= lane + 2'd1;
            if (lane == 2'd3) buf_valid <= hs;
            if (last_smp) begin
              // unused lanes of the final word are dropped
              buf_valid <= 1'b0;
              lane      <= '0;
            end
          end else if (hs) begin
            buf_valid <= 1'b1;
            lane      <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hash_sample_unpack.sv
// Directed testbench for hash_sample_unpack. Word w carries samples
// 4w+1..4w+4 in lanes 0..3, so the k-th write of a job must carry k.
module tb_hash_sample_unpack;

  logic        clk, rstn, start, abort;
  logic [2:0]  mode;
  logic [1:0]  level;
  logic        busy, done, hash_valid, hash_ready;
  logic [63:0] hash_data;
  logic        smp_we, agu_addr_clr, agu_add_en;
  logic [15:0] smp_data;
  logic [2:0]  agu_mode;
  logic [1:0]  agu_level;

  hash_sample_unpack #(.W_HASH(64), .W_SMP(16)) dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort),
    .mode(mode), .level(level), .busy(busy), .done(done),
    .hash_valid(hash_valid), .hash_data(hash_data), .hash_ready(hash_ready),
    .smp_we(smp_we), .smp_data(smp_data), .agu_addr_clr(agu_addr_clr),
    .agu_add_en(agu_add_en), .agu_mode(agu_mode), .agu_level(agu_level)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // observation counters, cleared per job
  int wr_cnt, words, order_err, add_err, ready_hi, ready_late, job_words;
  int first_cyc, last_cyc, clr_cyc, done_cyc, done_cnt;
  logic [15:0] first4 [4];

  // source controls
  logic src_en = 1'b0;
  logic stall  = 1'b0;

  function automatic logic [63:0] make_word(input int w);
    int b;
    b = 4 * w + 1;
    return {16'(b + 3), 16'(b + 2), 16'(b + 1), 16'(b)};
  endfunction

  initial begin
    hash_valid = 1'b0;
    hash_data  = '0;
    forever begin
      @(posedge clk); #1;
      hash_valid = src_en && !stall;
      hash_data  = make_word(words);
    end
  end

  always @(negedge clk) begin
    if (smp_we) begin
      if (wr_cnt == 0) first_cyc = cyc;
      last_cyc = cyc;
      if (smp_data != 16'(wr_cnt + 1)) order_err++;
      if (wr_cnt < 4) first4[wr_cnt] = smp_data;
      wr_cnt++;
    end
    if (agu_add_en != smp_we) add_err++;
    if (hash_ready) begin
      ready_hi++;
      if (job_words > 0 && words >= job_words) ready_late++;
    end
    if (hash_valid && hash_ready) words++;
    if (agu_addr_clr) clr_cyc = cyc;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic clear_counts(input int jw);
    wr_cnt = 0; words = 0; order_err = 0; add_err = 0; ready_hi = 0;
    ready_late = 0; job_words = jw; first_cyc = -1; last_cyc = -1;
    clr_cyc = -1; done_cyc = -1; done_cnt = 0;
  endtask

  task automatic pulse_start(input logic [2:0] m, input logic [1:0] l, output int s);
    @(posedge clk); #1;
    mode = m; level = l; start = 1'b1; s = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_job(input string tag, input logic [2:0] m, input logic [1:0] l,
                         input int exp_total, input int stall_at);
    int s, stall_left, span;
    bit stalled;
    stalled = 0; stall_left = 0;
    @(posedge clk); #1;
    clear_counts(exp_total / 4);
    pulse_start(m, l, s);
    for (int i = 0; i < exp_total + 200; i++) begin
      if (done_cnt > 0) break;
      if (stall_at >= 0 && !stalled && wr_cnt >= stall_at) begin
        stall = 1'b1; stalled = 1; stall_left = 10;
      end else if (stall) begin
        stall_left--;
        if (stall_left == 0) stall = 1'b0;
      end
      @(posedge clk); #1;
    end
    stall = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_done_cnt"}, done_cnt, 1);
    check({tag, "_clr_cyc"}, clr_cyc, s + 1);
    check({tag, "_writes"}, wr_cnt, exp_total);
    check({tag, "_words"}, words, exp_total / 4);
    check({tag, "_order"}, order_err, 0);
    check({tag, "_add_en"}, add_err, 0);
    check({tag, "_ready_late"}, ready_late, 0);
    check({tag, "_mode"}, {29'd0, agu_mode}, {29'd0, m});
    check({tag, "_level"}, {30'd0, agu_level}, {30'd0, l});
    check({tag, "_busy_end"}, {31'd0, busy}, 0);
    if (exp_total == 0) begin
      check({tag, "_done_cyc"}, done_cyc, s + 2);
      check({tag, "_ready_hi"}, ready_hi, 0);
    end else begin
      check({tag, "_first_cyc"}, first_cyc, s + 3);
      check({tag, "_done_cyc"}, done_cyc, last_cyc + 1);
      span = last_cyc - first_cyc + 1;
      if (stall_at >= 0) check({tag, "_gap"}, {31'd0, span > exp_total}, 1);
      else               check({tag, "_span"}, span, exp_total);
    end
  endtask

  int s0;

  initial begin
    rstn = 1'b0; start = 1'b0; abort = 1'b0; mode = '0; level = '0;
    clear_counts(0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_ctrl", {26'd0, busy, done, smp_we, agu_add_en, agu_addr_clr, hash_ready}, 0);
    check("rst_smp_data", {16'd0, smp_data}, 0);
    check("rst_agu", {27'd0, agu_mode, agu_level}, 0);
    @(negedge clk);
    rstn = 1'b1;
    src_en = 1'b1;

    run_job("e_prime", 3'b001, 2'b11, 64, -1);
    check("e_prime_s0", {16'd0, first4[0]}, 16'h0001);
    check("e_prime_s1", {16'd0, first4[1]}, 16'h0002);
    check("e_prime_s2", {16'd0, first4[2]}, 16'h0003);
    check("e_prime_s3", {16'd0, first4[3]}, 16'h0004);

    run_job("s_640", 3'b000, 2'b11, 5120, -1);
    run_job("b_976", 3'b100, 2'b10, 976, -1);
    run_job("b_1344_stall", 3'b100, 2'b01, 1344, 202);
    run_job("lvl0", 3'b000, 2'b00, 0, -1);

    // abort after 100 writes
    @(posedge clk); #1;
    clear_counts(0);
    pulse_start(3'b000, 2'b11, s0);
    for (int i = 0; i < 300; i++) begin
      if (wr_cnt >= 100) break;
      @(posedge clk); #1;
    end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_busy", {31'd0, busy}, 0);
    check("abort_we", {31'd0, smp_we}, 0);
    repeat (5) @(posedge clk);
    #1;
    check("abort_writes", wr_cnt, 101);
    check("abort_no_done", done_cnt, 0);
    check("abort_ready", {31'd0, hash_ready}, 0);

    run_job("after_abort", 3'b001, 2'b11, 64, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
